// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int STOP_BITS  = 1;

  // Bit positions in the register block's ctrl and status words
  localparam int CTRL_TX_EN         = 0;
  localparam int CTRL_TX_INT_EN     = 2;
  localparam int CTRL_TX_OVR_INT_EN = 4;
  localparam int CTRL_HS_TEST       = 6;
  localparam int STAT_TX_FULL       = 0;
  localparam int STAT_TX_OVERRUN    = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous first-word-fall-through FIFO for TX bytes
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is legal when a pop frees a slot in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - FIFO-fed 8N1 UART transmitter with divisor-driven bit timing
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CD_W       = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CD_W-1:0]   cd,
  input  logic              tx_en,
  input  logic              tx_int_en,
  input  logic              tx_ovr_int_en,
  input  logic              hs_test,
  input  logic              ovr_clr,
  output logic              txd,
  output logic              tx_ack,
  output logic              tx_done,
  output logic              tx_full,
  output logic              tx_overrun,
  output logic              tx_irq,
  output logic              tx_busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_t         state, state_d;
  logic              wr_q, push_req, accept, pop;
  logic [DATA_W-1:0] fifo_rdata, shift;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CD_W-1:0]   cd_lat, div_lim, div_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              div_wrap, tick, bit_end, done_evt, done_q;

  assign push_req = tx_wr & ~wr_q;
  assign accept   = push_req & (~fifo_full | pop);
  assign div_lim  = (cd_lat == '0) ? CD_W'(1) : cd_lat;
  assign div_wrap = (div_cnt == div_lim - CD_W'(1));
  assign tick     = hs_test | div_wrap;
  assign bit_end  = tick & (os_cnt == OS_LAST);

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .push   (push_req),
    .pop    (pop),
    .wdata  (tx_data),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    done_evt = 1'b0;
    case (state)
      IDLE: if (tx_en && !fifo_empty) begin
        pop     = 1'b1;
        state_d = START;
      end
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_cnt == DATA_LAST) state_d = STOP;
      STOP: if (bit_end && bit_cnt == STOP_LAST) begin
        done_evt = 1'b1;
        // Chain straight into the next start bit so queued bytes leave without a gap
        if (tx_en && !fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      shift   <= '0;
      cd_lat  <= '0;
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      shift   <= fifo_rdata;
      cd_lat  <= cd;
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else if (state != IDLE) begin
      div_cnt <= div_wrap ? '0 : div_cnt + CD_W'(1);
      if (tick) os_cnt <= os_cnt + OS_W'(1);
      if (bit_end && state != START) begin
        bit_cnt <= (state == DATA && bit_cnt == DATA_LAST) ? '0 : bit_cnt + BIT_W'(1);
        if (state == DATA) shift <= shift >> 1;
      end
    end
  end

  // Outputs follow the state register by one cycle, so txd and tx_done stay aligned
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_q       <= 1'b0;
      txd        <= 1'b1;
      tx_ack     <= 1'b0;
      done_q     <= 1'b0;
      tx_done    <= 1'b0;
      tx_overrun <= 1'b0;
      tx_irq     <= 1'b0;
      tx_busy    <= 1'b0;
    end else begin
      wr_q    <= tx_wr;
      tx_ack  <= accept;
      done_q  <= done_evt;
      tx_done <= done_q;
      tx_busy <= (state != IDLE);
      if (state == START)     txd <= 1'b0;
      else if (state == DATA) txd <= shift[0];
      else                    txd <= 1'b1;
      if (push_req && !accept) tx_overrun <= 1'b1;
      else if (ovr_clr)        tx_overrun <= 1'b0;
      tx_irq <= (tx_int_en && fifo_count == '0 && state == IDLE) ||
                (tx_ovr_int_en && tx_overrun);
    end
  end

  assign tx_full = fifo_full;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench decoding txd frames against pushed bytes
module tb_uart_tx_engine;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        tx_wr = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic [12:0] cd = 13'd0;
  logic        tx_en = 1'b0;
  logic        tx_int_en = 1'b0;
  logic        tx_ovr_int_en = 1'b0;
  logic        hs_test = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        txd, tx_ack, tx_done, tx_full, tx_overrun, tx_irq, tx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  uart_tx_engine #(.DATA_W(8), .CD_W(13), .FIFO_DEPTH(4)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .tx_wr         (tx_wr),
    .tx_data       (tx_data),
    .cd            (cd),
    .tx_en         (tx_en),
    .tx_int_en     (tx_int_en),
    .tx_ovr_int_en (tx_ovr_int_en),
    .hs_test       (hs_test),
    .ovr_clr       (ovr_clr),
    .txd           (txd),
    .tx_ack        (tx_ack),
    .tx_done       (tx_done),
    .tx_full       (tx_full),
    .tx_overrun    (tx_overrun),
    .tx_irq        (tx_irq),
    .tx_busy       (tx_busy)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic do_reset();
    PRESET = 1'b1; tx_wr = 1'b0; ovr_clr = 1'b0;
    step(2);
    PRESET = 1'b0;
    step(1);
  endtask

  task automatic push_byte(input logic [7:0] d, output logic acked);
    tx_data = d; tx_wr = 1'b1;
    step(1);
    acked = tx_ack; tx_wr = 1'b0;
    step(1);
  endtask

  // Decodes one frame starting at the current negedge; optional pushes at given offsets
  task automatic rx_frame(input int bit_len, input int inj1, input logic [7:0] d1,
                          input int inj2, input logic [7:0] d2, output int start_cyc);
    logic [9:0] exp_bits;
    logic [7:0] exp_b, got;
    int w, k, pos, bad_off;
    w = 0; got = 8'h00; bad_off = -1; start_cyc = -1;
    while (txd !== 1'b0 && w < 3000) begin step(1); w++; end
    start_cyc = cyc;
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL rx_start: txd=%b after %0d cycles, required start bit 0", txd, w);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rx_unexpected: frame seen, required no frame (queue empty)");
      exp_b = 8'h00;
    end else begin
      exp_b = exp_q.pop_front();
    end
    exp_bits = {1'b1, exp_b, 1'b0};
    for (int off = 0; off <= 10 * bit_len; off++) begin
      if (off < 10 * bit_len) begin
        k = off / bit_len; pos = off % bit_len;
        if (txd !== exp_bits[k] && bad_off < 0) bad_off = off;
        if (off != 0 && tx_done !== 1'b0 && bad_off < 0) bad_off = off;
        if (pos == bit_len / 2 && k >= 1 && k <= 8) got[k-1] = txd;
      end else if (tx_done !== 1'b1 && bad_off < 0) begin
        bad_off = off;
      end
      if (inj1 >= 0 && off == inj1 + 1) begin
        tx_wr = 1'b0;
        checks++;
        if (tx_ack !== 1'b1 || tx_overrun !== 1'b0) begin
          errors++;
          $display("FAIL inj1_ack: ack=%b ovr=%b, required ack=1 ovr=0", tx_ack, tx_overrun);
        end
      end
      if (inj2 >= 0 && off == inj2 + 1) begin
        tx_wr = 1'b0;
        checks++;
        if (tx_ack !== 1'b1 || tx_overrun !== 1'b0) begin
          errors++;
          $display("FAIL inj2_ack: ack=%b ovr=%b, required ack=1 ovr=0", tx_ack, tx_overrun);
        end
      end
      if (off == inj1) begin tx_data = d1; tx_wr = 1'b1; exp_q.push_back(d1); end
      if (off == inj2) begin tx_data = d2; tx_wr = 1'b1; exp_q.push_back(d2); end
      if (off < 10 * bit_len) step(1);
    end
    checks++;
    if (got !== exp_b) begin
      errors++;
      $display("FAIL rx_data: got %h, required %h", got, exp_b);
    end
    checks++;
    if (bad_off >= 0) begin
      errors++;
      $display("FAIL rx_timing: frame %h deviated at offset %0d, required exact %0d-cycle bits and tx_done at %0d",
               exp_b, bad_off, bit_len, 10 * bit_len);
    end
  endtask

  task automatic expect_idle(input int n, input string name);
    bit ok;
    ok = 1'b1;
    repeat (n) begin
      step(1);
      if (txd !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: line active (txd=%b busy=%b), required idle", name, txd, tx_busy);
    end
  endtask

  task automatic test_reset();
    tx_int_en = 1'b1;
    PRESET = 1'b1;
    step(3);
    checks++;
    if ({txd, tx_ack, tx_done, tx_full, tx_overrun, tx_irq, tx_busy} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 1000000",
               {txd, tx_ack, tx_done, tx_full, tx_overrun, tx_irq, tx_busy});
    end
    PRESET = 1'b0;
    step(2);
    checks++;
    if (tx_irq !== 1'b1) begin
      errors++;
      $display("FAIL reset_irq_empty: tx_irq=%b, required 1", tx_irq);
    end
  endtask

  task automatic test_hs_latency();
    int c0, s;
    hs_test = 1'b1; tx_en = 1'b1;
    tx_data = 8'hA5; tx_wr = 1'b1; exp_q.push_back(8'hA5);
    step(1);
    c0 = cyc; tx_wr = 1'b0;
    checks++;
    if (tx_ack !== 1'b1) begin
      errors++;
      $display("FAIL hs_ack: tx_ack=%b, required 1", tx_ack);
    end
    rx_frame(16, -1, 8'h00, -1, 8'h00, s);
    checks++;
    if (s - c0 != 2) begin
      errors++;
      $display("FAIL hs_latency: start %0d cycles after request, required 2", s - c0);
    end
    step(1);
    checks++;
    if (tx_irq !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_idle_irq: irq=%b busy=%b, required irq=1 busy=0", tx_irq, tx_busy);
    end
  endtask

  task automatic test_divisor();
    logic a;
    int s;
    hs_test = 1'b0; tx_en = 1'b1; cd = 13'd3;
    exp_q.push_back(8'h00);
    push_byte(8'h00, a);
    fork
      rx_frame(48, -1, 8'h00, -1, 8'h00, s);
      begin step(100); cd = 13'd0; end
    join
    exp_q.push_back(8'hC3);
    push_byte(8'hC3, a);
    rx_frame(16, -1, 8'h00, -1, 8'h00, s);
    hs_test = 1'b1;
  endtask

  task automatic test_hold();
    int acks, s;
    tx_en = 1'b0; acks = 0;
    tx_data = 8'h55; tx_wr = 1'b1; exp_q.push_back(8'h55);
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tx_ack === 1'b1) acks++;
    end
    tx_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (tx_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL hold_acks: got %0d acks, required 1", acks);
    end
    tx_en = 1'b1;
    rx_frame(16, -1, 8'h00, -1, 8'h00, s);
    expect_idle(200, "hold_single_frame");
  endtask

  task automatic test_full_overrun();
    logic a;
    int acks, s, prev;
    do_reset();
    tx_en = 1'b0; tx_int_en = 1'b0; tx_ovr_int_en = 1'b1; acks = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      push_byte(8'(i), a);
      if (a === 1'b1) acks++;
    end
    step(1);
    checks++;
    if (acks != 4 || tx_full !== 1'b1 || tx_overrun !== 1'b1 || tx_irq !== 1'b1) begin
      errors++;
      $display("FAIL full_overrun: acks=%0d full=%b ovr=%b irq=%b, required 4 1 1 1",
               acks, tx_full, tx_overrun, tx_irq);
    end
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    checks++;
    if (tx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: tx_overrun=%b, required 0", tx_overrun);
    end
    step(1);
    checks++;
    if (tx_irq !== 1'b0) begin
      errors++;
      $display("FAIL ovr_irq_clear: tx_irq=%b, required 0", tx_irq);
    end
    tx_en = 1'b1;
    rx_frame(16, -1, 8'h00, -1, 8'h00, prev);
    checks++;
    if (tx_full !== 1'b0) begin
      errors++;
      $display("FAIL full_drop: tx_full=%b, required 0", tx_full);
    end
    for (int i = 0; i < 3; i++) begin
      rx_frame(16, -1, 8'h00, -1, 8'h00, s);
      checks++;
      if (s - prev != 160) begin
        errors++;
        $display("FAIL b2b_gap: frame spacing %0d cycles, required 160", s - prev);
      end
      prev = s;
    end
    tx_ovr_int_en = 1'b0;
  endtask

  task automatic test_stop_pop();
    logic a;
    int s;
    do_reset();
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h11 * 8'(i + 1));
      push_byte(8'h11 * 8'(i + 1), a);
    end
    checks++;
    if (tx_full !== 1'b1) begin
      errors++;
      $display("FAIL stop_pop_full: tx_full=%b, required 1", tx_full);
    end
    tx_en = 1'b1;
    rx_frame(16, 20, 8'h55, 158, 8'h66, s);
    for (int i = 0; i < 5; i++) rx_frame(16, -1, 8'h00, -1, 8'h00, s);
    checks++;
    if (tx_overrun !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stop_pop_ovr: ovr=%b pending=%0d, required 0 0", tx_overrun, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    int s;
    do_reset();
    hs_test = 1'b1; tx_en = 1'b1; tx_int_en = 1'b1;
    push_byte(8'h3C, a);
    push_byte(8'h77, a);
    step(69);
    PRESET = 1'b1;
    step(1);
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0 || tx_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: txd=%b busy=%b full=%b ack=%b, required 1 0 0 0",
               txd, tx_busy, tx_full, tx_ack);
    end
    PRESET = 1'b0;
    step(2);
    checks++;
    if (tx_irq !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_empty: tx_irq=%b, required 1", tx_irq);
    end
    expect_idle(50, "mid_reset_flushed");
    exp_q.push_back(8'hE1);
    push_byte(8'hE1, a);
    rx_frame(16, -1, 8'h00, -1, 8'h00, s);
  endtask

  initial begin
    test_reset();
    test_hs_latency();
    test_divisor();
    test_hold();
    test_full_overrun();
    test_stop_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
